mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between instruction fetch and the load/store path. Data accesses come from the decoder's MemRead/MemWrite. One transaction is outstanding at a time. Data has priority, and a starvation limit guarantees fetch progress. Pipeline stalls are generated until each requester's access completes. The block sits between the fetch/memory stages and the external memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-enable width = DATA_W/8)
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word (= mem_rdata)
- if_valid  out  1  fetch completes this cycle
- if_stall  out  1  if_req && !if_valid
- dm_read, dm_write  in  1 each  load/store request, held until dm_valid
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data (= mem_rdata)
- dm_valid  out  1  data access completes this cycle
- dm_stall  out  1  (dm_read||dm_write) && !dm_valid
- mem_req  out  1  request to memory
- mem_we  out  1  write
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response (reads and writes) this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid

## Operation
- FSM: IDLE, REQ, RESP.
- IDLE, one of the following applies:
  - No request pending: stay in IDLE.
  - Otherwise: select owner, latch owner's addr/wdata/be/we into mem_* registers, go to REQ.
- REQ: mem_req=1 with latched fields stable. On mem_gnt go to RESP; otherwise hold.
- RESP: on mem_rvalid, assert the owner's valid combinationally with mem_rvalid, then go to IDLE.
- Owner selection:
  - Data beats fetch.
  - Exception: fetch wins when streak==STARVE_LIMIT and if_req is pending.
- streak counter (0..STARVE_LIMIT), updated only when leaving IDLE:
  - Data grant with if_req high: streak+1, saturating.
  - Data grant with if_req low: 0.
  - Fetch grant: 0.
- dm_read && dm_write both high: treated as write.
- Fetch is read-only: for a fetch, mem_we=0 and mem_be=all ones.
- For a data read, mem_be = all ones and mem_wdata is don't-care but must be latched deterministically from dm_wdata.
- mem_rvalid outside RESP is ignored; no valid is generated.
- if_valid and dm_valid are never high in the same cycle.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, streak 0, if_valid/dm_valid 0.
- Reset asserted mid-transaction: the transaction is abandoned and mem_req drops immediately (async). A late mem_rvalid after release is ignored in IDLE.

## Timing
- Request seen in IDLE at cycle N: mem_req high from N+1.
- With mem_gnt at N+1: RESP at N+2. Earliest valid is N+2 if mem_rvalid arrives then. Minimum 3 cycles per access.
- Each added gnt or rvalid wait cycle adds one cycle.
- A new request is sampled in the IDLE cycle after valid, so back-to-back accesses occur every 3 cycles at best.
- Requester drops or changes its request on the edge after its valid; the arbiter never re-issues a completed request.
- if_stall/dm_stall are combinational from requests and valid; no other combinational paths from mem_* to mem_*.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, REQ, RESP)
  - owner enum (OWN_IF, OWN_DM)
  - default widths
- Sub-module arb_starve_sel: owner selection plus streak counter, clocked on the same clk/rst_n.
- Top holds the FSM, latch registers and output muxing.

## Test plan
- Lone fetch, if_addr=0x100, gnt immediate, rvalid at N+2 with 0x00500093: if_valid at N+2 with that data; if_stall high N..N+1, low at N+2.
- Simultaneous if_req and dm_read (0x2000): data issued first (mem_we=0, addr 0x2000); fetch issued after data's valid, 3 cycles later.
- dm_write addr 0x40, wdata 0xDEADBEEF, be 0b0011, mem_gnt delayed 2 cycles: mem_req/addr/wdata/be stable through the wait; mem_we=1; dm_valid on rvalid.
- Data requests continuously pending with if_req held: fetch granted after exactly 4 data grants; streak returns to 0.
- rst_n asserted in RESP: mem_req 0 and state IDLE at once; a stray mem_rvalid after release produces no valid.
- mem_rvalid pulsed while IDLE or REQ: no if_valid/dm_valid; FSM unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and default widths for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: external single-port memory bus between arbiter and memory
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_arb_starve_sel.sv
// arb_starve_sel: data-first owner selection with a streak limit that forces fetch through
module arb_starve_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req_i,
    input  logic   dm_req_i,
    input  logic   take_i,
    output owner_e owner_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] streak_q, streak_d;
    assign owner_o = (dm_req_i && !(if_req_i && streak_q == LIMIT)) ? OWN_DM : OWN_IF;
    // streak grows only while data wins over a waiting fetch, saturating at the limit
    always_comb begin
        streak_d = (owner_o == OWN_DM && if_req_i) ? ((streak_q == LIMIT) ? streak_q : streak_q + 1'b1) : '0;
    end
    // streak is committed only on the cycle a grant leaves IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else if (take_i) streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                dm_read,
    input  logic                dm_write,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,
    mem_port_arbiter_if.master  mem
);
    state_e              state_q;
    owner_e              owner_q, owner_sel;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_be_q;
    logic                dm_req, take, is_dm, done;
    assign dm_req = dm_read | dm_write;
    assign take   = (state_q == IDLE) && (if_req || dm_req);
    assign is_dm  = owner_sel == OWN_DM;
    arb_starve_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .take_i   (take),
        .owner_o  (owner_sel)
    );
    // transaction FSM; the winner's fields are frozen into mem_* on leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    state_q     <= REQ;
                    owner_q     <= owner_sel;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= is_dm && dm_write;
                    mem_addr_q  <= is_dm ? dm_addr : if_addr;
                    mem_wdata_q <= is_dm ? dm_wdata : '0;
                    mem_be_q    <= (is_dm && dm_write) ? dm_be : '1;
                end
                REQ: if (mem.mem_gnt) begin
                    state_q   <= RESP;
                    mem_req_q <= 1'b0;
                end
                RESP: if (mem.mem_rvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign done          = (state_q == RESP) && mem.mem_rvalid;
    assign if_valid      = done && owner_q == OWN_IF;
    assign dm_valid      = done && owner_q == OWN_DM;
    assign if_rdata      = mem.mem_rdata;
    assign dm_rdata      = mem.mem_rdata;
    assign if_stall      = if_req && !if_valid;
    assign dm_stall      = dm_req && !dm_valid;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall;
    int          nvec = 0, nerr = 0;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();
    mem_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .dm_stall (dm_stall),
        .mem      (mif.master)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // memory side of one access starting in the REQ cycle; ends in the following IDLE cycle
    task automatic serve(input int gw, input logic [31:0] rd, output logic [31:0] a,
                         output logic w, output logic iv, output logic dv);
        a = mif.mem_addr;
        w = mif.mem_we;
        repeat (gw) tick();
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = rd;
        #1;
        iv = if_valid;
        dv = dm_valid;
        tick();
        mif.mem_rvalid = 1'b0;
    endtask
    task automatic test_reset();
        tick();
        tick();
        nvec++; if (mif.mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req got %b want 0", mif.mem_req); end
        nvec++; if (mif.mem_we !== 1'b0) begin nerr++; $display("FAIL rst_mem_we got %b want 0", mif.mem_we); end
        nvec++; if (mif.mem_addr !== 32'h0) begin nerr++; $display("FAIL rst_mem_addr got %h want 0", mif.mem_addr); end
        nvec++; if (mif.mem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_mem_wdata got %h want 0", mif.mem_wdata); end
        nvec++; if (mif.mem_be !== 4'h0) begin nerr++; $display("FAIL rst_mem_be got %h want 0", mif.mem_be); end
        nvec++; if ({if_valid, dm_valid} !== 2'b00) begin nerr++; $display("FAIL rst_valids got %b want 00", {if_valid, dm_valid}); end
        nvec++; if (dut.state_q !== IDLE) begin nerr++; $display("FAIL rst_state got %0d want IDLE", dut.state_q); end
        rst_n = 1'b1;
        tick();
    endtask
    task automatic test_lone_fetch();
        if_req = 1'b1;
        if_addr = 32'h100;
        #1;
        nvec++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL lf_stall_n got %b want 1", if_stall); end
        nvec++; if (mif.mem_req !== 1'b0) begin nerr++; $display("FAIL lf_req_n got %b want 0", mif.mem_req); end
        tick();
        nvec++; if (mif.mem_req !== 1'b1) begin nerr++; $display("FAIL lf_req_n1 got %b want 1", mif.mem_req); end
        nvec++; if (mif.mem_addr !== 32'h100) begin nerr++; $display("FAIL lf_addr got %h want 100", mif.mem_addr); end
        nvec++; if ({mif.mem_we, mif.mem_be} !== 5'b0_1111) begin nerr++; $display("FAIL lf_we_be got %b want 01111", {mif.mem_we, mif.mem_be}); end
        nvec++; if (if_stall !== 1'b1) begin nerr++; $display("FAIL lf_stall_n1 got %b want 1", if_stall); end
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 32'h00500093;
        #1;
        nvec++; if (if_valid !== 1'b1) begin nerr++; $display("FAIL lf_valid got %b want 1", if_valid); end
        nvec++; if (if_rdata !== 32'h00500093) begin nerr++; $display("FAIL lf_rdata got %h want 00500093", if_rdata); end
        nvec++; if (if_stall !== 1'b0) begin nerr++; $display("FAIL lf_stall_n2 got %b want 0", if_stall); end
        nvec++; if (dm_valid !== 1'b0) begin nerr++; $display("FAIL lf_dm_valid got %b want 0", dm_valid); end
        tick();
        mif.mem_rvalid = 1'b0;
        if_req = 1'b0;
        #1;
        nvec++; if (if_valid !== 1'b0 || dut.state_q !== IDLE) begin nerr++; $display("FAIL lf_after got valid=%b state=%0d want 0/IDLE", if_valid, dut.state_q); end
    endtask
    task automatic test_priority();
        logic [31:0] a;
        logic w, iv, dv;
        if_req = 1'b1;
        if_addr = 32'h100;
        dm_read = 1'b1;
        dm_addr = 32'h2000;
        tick();
        nvec++; if (mif.mem_addr !== 32'h2000 || mif.mem_we !== 1'b0) begin nerr++; $display("FAIL pr_first got addr=%h we=%b want 2000/0", mif.mem_addr, mif.mem_we); end
        serve(0, 32'h11112222, a, w, iv, dv);
        nvec++; if ({iv, dv} !== 2'b01) begin nerr++; $display("FAIL pr_data_valid got if/dm=%b want 01", {iv, dv}); end
        dm_read = 1'b0;
        #1;
        nvec++; if (mif.mem_req !== 1'b0 || if_stall !== 1'b1) begin nerr++; $display("FAIL pr_gap got req=%b stall=%b want 0/1", mif.mem_req, if_stall); end
        tick();
        nvec++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100) begin nerr++; $display("FAIL pr_fetch got req=%b addr=%h want 1/100", mif.mem_req, mif.mem_addr); end
        serve(0, 32'h33334444, a, w, iv, dv);
        nvec++; if ({iv, dv} !== 2'b10) begin nerr++; $display("FAIL pr_fetch_valid got if/dm=%b want 10", {iv, dv}); end
        if_req = 1'b0;
    endtask
    task automatic test_write_wait();
        dm_write = 1'b1;
        dm_addr = 32'h40;
        dm_wdata = 32'hDEADBEEF;
        dm_be = 4'b0011;
        tick();
        for (int k = 0; k < 3; k++) begin
            nvec++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin nerr++; $display("FAIL ww_req_we[%0d] got %b%b want 11", k, mif.mem_req, mif.mem_we); end
            nvec++; if (mif.mem_addr !== 32'h40 || mif.mem_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL ww_addr_data[%0d] got %h/%h want 40/deadbeef", k, mif.mem_addr, mif.mem_wdata); end
            nvec++; if (mif.mem_be !== 4'b0011) begin nerr++; $display("FAIL ww_be[%0d] got %b want 0011", k, mif.mem_be); end
            if (k == 2) mif.mem_gnt = 1'b1;
            tick();
        end
        mif.mem_gnt = 1'b0;
        #1;
        nvec++; if (dm_valid !== 1'b0 || dm_stall !== 1'b1) begin nerr++; $display("FAIL ww_pre got valid=%b stall=%b want 0/1", dm_valid, dm_stall); end
        mif.mem_rvalid = 1'b1;
        #1;
        nvec++; if ({if_valid, dm_valid, dm_stall} !== 3'b010) begin nerr++; $display("FAIL ww_valid got %b want 010", {if_valid, dm_valid, dm_stall}); end
        tick();
        mif.mem_rvalid = 1'b0;
        dm_write = 1'b0;
    endtask
    task automatic test_data_fields();
        logic [31:0] a;
        logic w, iv, dv;
        dm_read = 1'b1;
        dm_write = 1'b1;
        dm_addr = 32'h80;
        dm_wdata = 32'h12345678;
        dm_be = 4'b0101;
        tick();
        nvec++; if (mif.mem_we !== 1'b1 || mif.mem_be !== 4'b0101) begin nerr++; $display("FAIL rw_both got we=%b be=%b want 1/0101", mif.mem_we, mif.mem_be); end
        serve(1, 32'h0, a, w, iv, dv);
        nvec++; if ({iv, dv} !== 2'b01) begin nerr++; $display("FAIL rw_both_valid got %b want 01", {iv, dv}); end
        dm_write = 1'b0;
        dm_addr = 32'h84;
        dm_wdata = 32'hCAFEF00D;
        dm_be = 4'b0010;
        tick();
        nvec++; if ({mif.mem_we, mif.mem_be} !== 5'b0_1111 || mif.mem_wdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL rd_fields got we=%b be=%b wdata=%h want 0/1111/cafef00d", mif.mem_we, mif.mem_be, mif.mem_wdata); end
        serve(0, 32'h5A5A5A5A, a, w, iv, dv);
        nvec++; if ({iv, dv} !== 2'b01) begin nerr++; $display("FAIL rd_valid got %b want 01", {iv, dv}); end
        dm_read = 1'b0;
    endtask
    task automatic test_starvation();
        logic [31:0] a, fa, da;
        logic w, iv, dv, f;
        fa = 32'h1000;
        da = 32'h2000;
        if_req = 1'b1;
        dm_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f = (i == 4) || (i == 9);
            if_addr = fa;
            dm_addr = da;
            tick();
            serve(0, 32'(i), a, w, iv, dv);
            nvec++; if (a !== (f ? fa : da) || {iv, dv} !== {f, !f}) begin nerr++; $display("FAIL starve[%0d] got addr=%h if/dm=%b want %h/%b", i, a, {iv, dv}, f ? fa : da, {f, !f}); end
            if (f) fa = fa + 4;
            else da = da + 4;
        end
        if_req = 1'b0;
        dm_read = 1'b0;
    endtask
    task automatic test_reset_mid();
        if_req = 1'b1;
        if_addr = 32'h200;
        tick();
        nvec++; if (mif.mem_req !== 1'b1) begin nerr++; $display("FAIL rm_req got %b want 1", mif.mem_req); end
        rst_n = 1'b0;
        #1;
        nvec++; if (mif.mem_req !== 1'b0 || dut.state_q !== IDLE) begin nerr++; $display("FAIL rm_req_drop got req=%b state=%0d want 0/IDLE", mif.mem_req, dut.state_q); end
        tick();
        rst_n = 1'b1;
        tick();
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        nvec++; if (dut.state_q !== RESP) begin nerr++; $display("FAIL rm_in_resp got %0d want RESP", dut.state_q); end
        rst_n = 1'b0;
        #1;
        nvec++; if (dut.state_q !== IDLE || mif.mem_req !== 1'b0 || if_valid !== 1'b0) begin nerr++; $display("FAIL rm_resp_abort got state=%0d req=%b valid=%b want IDLE/0/0", dut.state_q, mif.mem_req, if_valid); end
        if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mif.mem_rvalid = 1'b1;
        #1;
        nvec++; if ({if_valid, dm_valid} !== 2'b00) begin nerr++; $display("FAIL rm_late_rvalid got %b want 00", {if_valid, dm_valid}); end
        tick();
        mif.mem_rvalid = 1'b0;
        nvec++; if (dut.state_q !== IDLE) begin nerr++; $display("FAIL rm_state got %0d want IDLE", dut.state_q); end
    endtask
    task automatic test_stray_rvalid();
        logic [31:0] a;
        logic w, iv, dv;
        mif.mem_rvalid = 1'b1;
        #1;
        nvec++; if ({if_valid, dm_valid} !== 2'b00) begin nerr++; $display("FAIL sr_idle got %b want 00", {if_valid, dm_valid}); end
        tick();
        mif.mem_rvalid = 1'b0;
        nvec++; if (dut.state_q !== IDLE) begin nerr++; $display("FAIL sr_idle_state got %0d want IDLE", dut.state_q); end
        dm_read = 1'b1;
        dm_addr = 32'h300;
        tick();
        mif.mem_rvalid = 1'b1;
        #1;
        nvec++; if ({if_valid, dm_valid} !== 2'b00) begin nerr++; $display("FAIL sr_req got %b want 00", {if_valid, dm_valid}); end
        tick();
        mif.mem_rvalid = 1'b0;
        nvec++; if (dut.state_q !== REQ || mif.mem_req !== 1'b1) begin nerr++; $display("FAIL sr_req_hold got state=%0d req=%b want REQ/1", dut.state_q, mif.mem_req); end
        serve(0, 32'h77, a, w, iv, dv);
        nvec++; if ({iv, dv} !== 2'b01 || a !== 32'h300) begin nerr++; $display("FAIL sr_done got if/dm=%b addr=%h want 01/300", {iv, dv}, a); end
        dm_read = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata = '0;
        test_reset();
        test_lone_fetch();
        test_priority();
        test_write_wait();
        test_data_fields();
        test_starvation();
        test_reset_mid();
        test_stray_rvalid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
